// File: rtl/riot_ports_if.sv
// Port-side signal bundle between the console input sources and riot_ports.
// The bench/board drives the master side; riot_ports is the slave.
interface riot_ports_if;
    logic [5:0] joy0;
    logic [5:0] joy1;
    logic       key_reset;
    logic       key_select;
    logic       key_pause;
    logic       key_ldiff;
    logic       key_rdiff;
    logic [7:0] PB_out;
    logic [7:0] PA_in;
    logic [7:0] PB_in;
    logic [5:0] inpt;
    logic [1:0] diff;

    modport master (
        output joy0, joy1, key_reset, key_select, key_pause, key_ldiff, key_rdiff, PB_out,
        input  PA_in, PB_in, inpt, diff
    );

    modport slave (
        input  joy0, joy1, key_reset, key_select, key_pause, key_ldiff, key_rdiff, PB_out,
        output PA_in, PB_in, inpt, diff
    );
endinterface

// File: rtl/riot_ports.sv
// Input conditioning for the 7800 RIOT ports: debounce, key stretch, difficulty latches, TIA fire decode.
// Define RIOT_PORTS_DEBOUNCE_EN to enable per-bit debounce; otherwise each input is a single ce register.
module riot_ports #(
    parameter int unsigned DEBOUNCE_CE = 8,
    parameter int unsigned HOLD_CE     = 16384,
    parameter logic [1:0]  DIFF_INIT   = 2'b00
) (
    input logic         clk,
    input logic         reset,
    input logic         ce,
    riot_ports_if.slave bus
);
    // stable bit map: [5:0] joy0, [11:6] joy1, 12 reset, 13 select, 14 pause, 15 ldiff, 16 rdiff
    localparam int          NB        = 17;
    localparam int          KEY_BASE  = 12;
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CE);

    logic [NB-1:0] raw_s;
    logic [NB-1:0] stable_r;
    logic [NB-1:0] stable_nxt_s;
    logic [4:0]    rise_s;
    logic [15:0]   hold_r     [3];
    logic [15:0]   hold_nxt_s [3];
    logic [2:0]    active_s;
    logic [1:0]    diff_r;
    logic [1:0]    diff_nxt_s;
    logic [7:0]    pa_nxt_s;
    logic [7:0]    pb_nxt_s;
    logic [5:0]    inpt_nxt_s;

    assign raw_s = {bus.key_rdiff, bus.key_ldiff, bus.key_pause, bus.key_select, bus.key_reset,
                    bus.joy1, bus.joy0};

`ifdef RIOT_PORTS_DEBOUNCE_EN
    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CE);

    logic [7:0] db_cnt_r     [NB];
    logic [7:0] db_cnt_nxt_s [NB];

    // Per-bit run counter of samples disagreeing with the stable value
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            if (raw_s[i] == stable_r[i]) begin
                db_cnt_nxt_s[i] = 8'd0;
                stable_nxt_s[i] = stable_r[i];
            end else if ((db_cnt_r[i] + 8'd1) == DB_LIMIT) begin
                db_cnt_nxt_s[i] = 8'd0;
                stable_nxt_s[i] = raw_s[i];
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i] + 8'd1;
                stable_nxt_s[i] = stable_r[i];
            end
        end
    end

    // Debounce counter storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) db_cnt_r[i] <= 8'd0;
        end else if (ce) begin
            for (int i = 0; i < NB; i++) db_cnt_r[i] <= db_cnt_nxt_s[i];
        end
    end
`else
    assign stable_nxt_s = raw_s;

    // Debounce depth has no effect in this build; an out-of-range value elaborates nothing
    if (DEBOUNCE_CE > 255) begin : g_debounce_unused
    end
`endif

    // Key edges, stretch counters, difficulty toggles and next output values
    always_comb begin
        rise_s = stable_nxt_s[16:12] & ~stable_r[16:12];
        for (int k = 0; k < 3; k++) begin
            if (rise_s[k]) begin
                hold_nxt_s[k] = HOLD_LOAD;
            end else if (hold_r[k] != 16'd0) begin
                hold_nxt_s[k] = hold_r[k] - 16'd1;
            end else begin
                hold_nxt_s[k] = hold_r[k];
            end
            active_s[k] = stable_r[KEY_BASE + k] | (hold_r[k] != 16'd0);
        end
        diff_nxt_s = diff_r ^ {rise_s[4], rise_s[3]};

        pa_nxt_s = ~{stable_r[0], stable_r[1], stable_r[2], stable_r[3],
                     stable_r[6], stable_r[7], stable_r[8], stable_r[9]};
        pb_nxt_s = {diff_nxt_s, 2'b11, ~active_s[2], 1'b1, ~active_s[1], ~active_s[0]};

        // PB_out bit set = one-button: INPT4/5 carry either fire, paddle-style lines read 0
        inpt_nxt_s[0] = bus.PB_out[2] ? 1'b0 : stable_r[5];
        inpt_nxt_s[1] = bus.PB_out[2] ? 1'b0 : stable_r[4];
        inpt_nxt_s[2] = bus.PB_out[4] ? 1'b0 : stable_r[11];
        inpt_nxt_s[3] = bus.PB_out[4] ? 1'b0 : stable_r[10];
        inpt_nxt_s[4] = bus.PB_out[2] ? ~(stable_r[4] | stable_r[5]) : 1'b1;
        inpt_nxt_s[5] = bus.PB_out[4] ? ~(stable_r[10] | stable_r[11]) : 1'b1;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r   <= '0;
            for (int k = 0; k < 3; k++) hold_r[k] <= 16'd0;
            diff_r     <= DIFF_INIT;
            bus.diff   <= DIFF_INIT;
            bus.PA_in  <= 8'hFF;
            bus.PB_in  <= {DIFF_INIT, 6'b111111};
            bus.inpt   <= 6'b110000;
        end else if (ce) begin
            stable_r   <= stable_nxt_s;
            for (int k = 0; k < 3; k++) hold_r[k] <= hold_nxt_s[k];
            diff_r     <= diff_nxt_s;
            bus.diff   <= diff_nxt_s;
            bus.PA_in  <= pa_nxt_s;
            bus.PB_in  <= pb_nxt_s;
            bus.inpt   <= inpt_nxt_s;
        end
    end
endmodule

// File: tb/tb_riot_ports.sv
// Directed bench for riot_ports with DEBOUNCE_CE=8, HOLD_CE=100, DIFF_INIT=2'b10.
module tb_riot_ports;
`ifdef RIOT_PORTS_DEBOUNCE_EN
    localparam int LAT = 8;
    localparam bit DB  = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit DB  = 1'b0;
`endif

    logic clk;
    logic reset;
    logic ce;
    int   n_checks;
    int   n_fail;

    riot_ports_if bus ();

    riot_ports #(
        .DEBOUNCE_CE (8),
        .HOLD_CE     (100),
        .DIFF_INIT   (2'b10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int first;
        int last;
        logic [7:0] exp_pa;

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        ce    = 1'b1;
        bus.joy0 = 6'd0;
        bus.joy1 = 6'd0;
        bus.key_reset  = 1'b0;
        bus.key_select = 1'b0;
        bus.key_pause  = 1'b0;
        bus.key_ldiff  = 1'b0;
        bus.key_rdiff  = 1'b0;
        bus.PB_out     = 8'h14;

        // reset state
        tick(2);
        check("rst_pa",   32'(bus.PA_in), 32'h0000_00FF);
        check("rst_pb",   32'(bus.PB_in), 32'h0000_00BF);
        check("rst_inpt", 32'(bus.inpt),  32'h0000_0030);
        check("rst_diff", 32'(bus.diff),  32'h0000_0002);
        reset = 1'b0;

        // joy0 up latency
        bus.joy0 = 6'b001000;
        tick(LAT);
        check("up_early", 32'(bus.PA_in), 32'h0000_00FF);
        tick(1);
        check("up_pa", 32'(bus.PA_in), 32'h0000_00EF);
        bus.joy0 = 6'd0;
        tick(LAT + 1);
        check("up_rel", 32'(bus.PA_in), 32'h0000_00FF);

        // 5-ce glitch on joy1 left
        bus.joy1 = 6'b000010;
        for (int t = 1; t <= 15; t++) begin
            if (t == 6) bus.joy1 = 6'd0;
            tick(1);
            exp_pa = (!DB && t >= 2 && t <= 6) ? 8'hFB : 8'hFF;
            check("glitch_pa", 32'(bus.PA_in), 32'(exp_pa));
        end

        // pause tap stretched to HOLD_CE
        cnt = 0; first = 0; last = 0;
        bus.key_pause = 1'b1;
        for (int t = 1; t <= LAT + 110; t++) begin
            if (t == 11) bus.key_pause = 1'b0;
            tick(1);
            if (bus.PB_in[3] == 1'b0) begin
                cnt++;
                if (first == 0) first = t;
                last = t;
            end
        end
        check("pause_len",   32'(cnt),   32'd100);
        check("pause_first", 32'(first), 32'(LAT + 1));
        check("pause_last",  32'(last),  32'(LAT + 100));

        // ldiff toggles twice, then both keys together
        bus.key_ldiff = 1'b1;
        tick(LAT + 2);
        bus.key_ldiff = 1'b0;
        tick(LAT + 2);
        check("ldiff1_diff", 32'(bus.diff), 32'd3);
        check("ldiff1_pb",   32'(bus.PB_in[7:6]), 32'd3);
        bus.key_ldiff = 1'b1;
        tick(LAT + 2);
        bus.key_ldiff = 1'b0;
        tick(LAT + 2);
        check("ldiff2_diff", 32'(bus.diff), 32'd2);
        check("ldiff2_pb",   32'(bus.PB_in[7:6]), 32'd2);
        bus.key_ldiff = 1'b1;
        bus.key_rdiff = 1'b1;
        tick(LAT + 2);
        bus.key_ldiff = 1'b0;
        bus.key_rdiff = 1'b0;
        tick(LAT + 2);
        check("both_diff", 32'(bus.diff), 32'd1);
        check("both_pb",   32'(bus.PB_in), 32'h0000_007F);

        // fire decode in one- and two-button modes
        bus.joy0 = 6'b010000;
        tick(LAT + 1);
        check("p0_one", 32'(bus.inpt), 32'h0000_0020);
        bus.PB_out = 8'h10;
        tick(1);
        check("p0_two", 32'(bus.inpt), 32'h0000_0032);
        bus.joy1 = 6'b100000;
        bus.PB_out = 8'h00;
        tick(LAT + 1);
        check("p1_two", 32'(bus.inpt), 32'h0000_0036);
        bus.PB_out = 8'h10;
        tick(1);
        check("p1_one", 32'(bus.inpt), 32'h0000_0012);
        bus.joy0 = 6'd0;
        bus.joy1 = 6'd0;
        bus.PB_out = 8'h14;
        tick(LAT + 1);
        check("fire_rel", 32'(bus.inpt), 32'h0000_0030);

        // ce low freezes everything
        ce = 1'b0;
        bus.joy0 = 6'b000001;
        tick(20);
        check("ce_hold", 32'(bus.PA_in), 32'h0000_00FF);
        ce = 1'b1;
        tick(LAT);
        check("ce_early", 32'(bus.PA_in), 32'h0000_00FF);
        tick(1);
        check("ce_right", 32'(bus.PA_in), 32'h0000_007F);
        bus.joy0 = 6'd0;
        tick(LAT + 1);

        // reset while select hold counter sits at 50
        bus.key_select = 1'b1;
        for (int t = 1; t <= LAT + 50; t++) begin
            if (t == LAT + 1) bus.key_select = 1'b0;
            tick(1);
        end
        check("sel_mid", 32'(bus.PB_in[1]), 32'd0);
        reset = 1'b1;
        tick(1);
        check("sel_rst",    32'(bus.PB_in[1]), 32'd1);
        check("sel_rst_pb", 32'(bus.PB_in), 32'h0000_00BF);
        reset = 1'b0;
        cnt = 0;
        for (int t = 1; t <= 60; t++) begin
            tick(1);
            if (bus.PB_in[1] == 1'b0) cnt++;
        end
        check("sel_no_resume", 32'(cnt), 32'd0);

        // key held across reset must re-qualify
        bus.key_select = 1'b1;
        tick(LAT + 1);
        check("sel_held", 32'(bus.PB_in[1]), 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(LAT);
        check("sel_requal_early", 32'(bus.PB_in[1]), 32'd1);
        tick(1);
        check("sel_requal", 32'(bus.PB_in[1]), 32'd0);
        bus.key_select = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riot_ports.md
# riot_ports

Input-conditioning stage directly upstream of the 7800 RIOT port inputs. Converts active-high joystick, fire and console-key requests into the active-low PA_in/PB_in bytes the RIOT samples. Also decodes the RIOT's PB2/PB4 two-button-mode outputs into TIA fire lines INPT0–INPT5. Console keys are debounced, stretched to a minimum hold, and difficulty keys are turned into latched switches.

## Interface
Parameters:
- DEBOUNCE_CE, default 8: consecutive ce samples a raw input must differ from its stable value before the stable value flips (range 1–255).
- HOLD_CE, default 16384: minimum number of ce cycles reset/select/pause stay asserted after a press (range 1–65535).
- DIFF_INIT, default 2'b00: reset state of the difficulty switches; bit1 = right, bit0 = left; 1 = A/pro.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous active-high reset; overrides ce.
- ce  in  1  PHI2 clock enable, same enable the RIOT uses. All state advances only when ce=1.
- joy0  in  6  player 0 {fire2, fire1, up, down, left, right}, active high.
- joy1  in  6  player 1, same layout.
- key_reset, key_select, key_pause  in  1 each  console keys, active high, momentary.
- key_ldiff, key_rdiff  in  1 each  difficulty toggle keys, active high, momentary.
- PB_out  in  8  RIOT port B output byte. Bit2 = P0 mode, bit4 = P1 mode; 0 = two-button.
- PA_in  out  8  to RIOT. Bits 7..4 = P0 {right, left, down, up}; bits 3..0 = P1 same order. Active low.
- PB_in  out  8  to RIOT. Bit7 = rdiff, bit6 = ldiff, bit3 = pause_n, bit1 = select_n, bit0 = reset_n. Bits 5, 4, 2 are constant 1 (pull-ups).
- inpt  out  6  to TIA INPT5..INPT0.
- diff  out  2  current latched difficulty state {right, left}, for OSD display.

## Operation
- Debounce, per bit: covers the 12 joystick direction/fire bits and the 5 keys.
  - Each bit has a stable value and a counter.
  - On ce, if raw == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CE, stable takes raw and the counter clears.
- Directions: PA_in = ~stable direction bits, mapped as above. Opposite directions pressed together both pass through unfiltered.
- Stretch, for reset, select and pause independently:
  - On a stable 0→1 edge, a 16-bit hold counter loads HOLD_CE.
  - The output stays asserted while stable=1 or the counter is nonzero. The counter decrements on ce.
  - A new edge while counting reloads the counter.
- Difficulty: on a stable 0→1 edge of key_ldiff/key_rdiff, the matching diff bit inverts. PB_in[7:6] = diff (1 = A).
- Fire, for player p (p0 uses PB_out[2], INPT0/1, INPT4; p1 uses PB_out[4], INPT2/3, INPT5):
  - Two-button mode (mode bit = 0):
    - INPT(2p) = fire2 stable.
    - INPT(2p+1) = fire1 stable; both active high.
    - INPT4/5 = 1.
  - One-button mode:
    - INPT(2p) = INPT(2p+1) = 0.
    - INPT4/5 = ~(fire1 | fire2).
- All outputs are registered.

## Timing
- Reset values:
  - PA_in = 8'hFF.
  - PB_in = {DIFF_INIT[1], DIFF_INIT[0], 6'b111111}.
  - inpt = 6'b110000.
  - diff = DIFF_INIT.
  - All counters 0; all stable values 0.
- Latency:
  - Raw input change held constant → output change on the ce edge after DEBOUNCE_CE + 1 ce cycles.
  - PB_out mode change → inpt update on the next ce edge.
- Stretched-key release: a tap shorter than HOLD_CE deasserts exactly HOLD_CE ce cycles after the stable edge. A long hold deasserts 1 ce after stable falls, provided the counter is already 0.
- ce=0: every register holds, including counters.
- Reset asserted mid-hold or mid-debounce: all state returns to reset values on that clock. A key still held afterwards must re-qualify through debounce.
- Simultaneous difficulty edges on both keys toggle both bits in the same cycle.

## Configuration
- RIOT_PORTS_DEBOUNCE_EN defined: debounce as described.
- Undefined: debounce logic is removed.
  - Each input passes through a single ce-qualified register (latency 1 ce).
  - Stretch and toggle edges are taken from that register.
  - All other behaviour is unchanged.

## Test plan
- Reset with DIFF_INIT=2'b10 → PA_in=FF, PB_in=8'hBF, inpt=6'b110000, diff=2'b10.
- joy0 up held for 8 ce (DEBOUNCE_CE=8) → PA_in[4]=0 on the 9th ce edge. A 5-ce glitch on joy1 left → PA_in unchanged.
- key_pause tapped for 10 ce with HOLD_CE=100 → PB_in[3]=0 for exactly 100 ce after debounce, then returns to 1.
- key_ldiff pressed twice with release between → diff[0] goes 0→1→0. PB_in[6] tracks it.
- PB_out[2]=1 with p0 fire1 → inpt[4]=0 and inpt[1:0]=00. Then PB_out[2]=0 → next ce inpt[1]=1, inpt[4]=1.
- Reset asserted while the select hold counter is at 50 → PB_in[1]=1 on the next clock. The counter does not resume after reset is released.
